// File: rtl/ieee_wrmux.sv
// Time-slot write multiplexer: shares one memory write port among NDR drives.
// Posts latched on ph2 are issued in fixed drive order, one slot per cycle.
module ieee_wrmux #(
   parameter int NDR       = 4,
   parameter int ADDRWIDTH = 14,
   parameter int DATAWIDTH = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            ph2,
   input  logic [NDR-1:0][ADDRWIDTH-1:0]   drv_addr,
   input  logic [NDR-1:0][DATAWIDTH-1:0]   drv_data,
   input  logic [NDR-1:0]                  drv_we,
   output logic [ADDRWIDTH-1:0]            mem_addr,
   output logic [DATAWIDTH-1:0]            mem_data,
   output logic                            mem_wren,
   output logic [1:0]                      drv_select,
   output logic [NDR-1:0]                  drv_ack,
   output logic [NDR-1:0]                  overrun
);

   localparam logic [2:0] SLOT_IDLE = 3'(NDR);

   logic [2:0]                    r_slot;
   logic [NDR-1:0]                r_pend;
   logic [NDR-1:0][ADDRWIDTH-1:0] r_buf_addr;
   logic [NDR-1:0][DATAWIDTH-1:0] r_buf_data;
   logic [ADDRWIDTH-1:0]          r_mem_addr;
   logic [DATAWIDTH-1:0]          r_mem_data;
   logic                          r_mem_wren;
   logic [1:0]                    r_drv_select;
   logic [NDR-1:0]                r_drv_ack;
   logic [NDR-1:0]                r_overrun;

   logic                          w_hit;
   logic [NDR-1:0]                w_ack;
   logic [1:0]                    w_idx;
   logic [ADDRWIDTH-1:0]          w_addr;
   logic [DATAWIDTH-1:0]          w_data;

   // Select the buffer owned by the current slot, if it has a post waiting.
   always_comb begin
      w_hit  = 1'b0;
      w_ack  = '0;
      w_idx  = 2'd0;
      w_addr = '0;
      w_data = '0;
      for (int k = 0; k < NDR; k++) begin
         if (r_slot == 3'(k) && r_pend[k]) begin
            w_hit    = 1'b1;
            w_ack[k] = 1'b1;
            w_idx    = 2'(k);
            w_addr   = r_buf_addr[k];
            w_data   = r_buf_data[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot       <= SLOT_IDLE;
         r_pend       <= '0;
         r_buf_addr   <= '0;
         r_buf_data   <= '0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_mem_wren   <= 1'b0;
         r_drv_select <= 2'd0;
         r_drv_ack    <= '0;
         r_overrun    <= '0;
      end else if (ph2) begin
         r_slot     <= 3'd0;
         r_mem_wren <= 1'b0;
         r_drv_ack  <= '0;
         for (int k = 0; k < NDR; k++) begin
            if (drv_we[k]) begin
               r_buf_addr[k] <= drv_addr[k];
               r_buf_data[k] <= drv_data[k];
               r_pend[k]     <= 1'b1;
               if (r_pend[k]) r_overrun[k] <= 1'b1;
            end
         end
      end else if (r_slot < SLOT_IDLE) begin
         // Empty slots still take their cycle so each drive keeps fixed timing.
         r_slot     <= r_slot + 3'd1;
         r_mem_wren <= w_hit;
         r_drv_ack  <= w_ack;
         r_pend     <= r_pend & ~w_ack;
         if (w_hit) begin
            r_mem_addr   <= w_addr;
            r_mem_data   <= w_data;
            r_drv_select <= w_idx;
         end
      end else begin
         r_mem_wren <= 1'b0;
         r_drv_ack  <= '0;
      end
   end

   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign mem_wren   = r_mem_wren;
   assign drv_select = r_drv_select;
   assign drv_ack    = r_drv_ack;
   assign overrun    = r_overrun;

endmodule

// File: doc/ieee_wrmux.md
Name: ieee_wrmux

Overview:
- Time-slot write multiplexer that lets up to NDR emulated IEEE drives share one write port of a dual-port memory (buffer RAM / disk track RAM).
- It is the write-direction counterpart of the shared ROM read multiplexer.
- Each drive posts at most one write per ph2 window; the block latches it, then issues the posted writes sequentially in fixed drive order in the cycles following ph2.

Parameters:
- NDR, 4, number of drives (1..4).
- ADDRWIDTH, 14, memory address width.
- DATAWIDTH, 8, memory data width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ph2  input  1  one-cycle strobe marking the drive CPU bus phase; requests are sampled here.
- drv_addr  input  ADDRWIDTH x NDR  per-drive write address.
- drv_data  input  DATAWIDTH x NDR  per-drive write data.
- drv_we  input  NDR  per-drive write request, sampled only when ph2=1.
- mem_addr  output  ADDRWIDTH  registered memory address.
- mem_data  output  DATAWIDTH  registered memory write data.
- mem_wren  output  1  registered memory write enable.
- drv_select  output  2  index of the drive owning the current mem_* cycle.
- drv_ack  output  NDR  one-cycle pulse, asserted together with mem_wren for the owning drive.
- overrun  output  NDR  sticky per-drive flag: the posted write was lost.

Behaviour:
- Reset: all outputs go to 0 (mem_addr, mem_data, mem_wren, drv_select, drv_ack, overrun). Pending bits are cleared and the slot counter is set to NDR (idle). Reset takes effect even mid-sequence, and in-flight pending writes are discarded.
- State: 3-bit slot counter; per-drive pending bit; per-drive latched addr/data buffers.
- ph2=1 cycle:
  - slot <= 0.
  - For each k with drv_we[k]=1: buf_addr[k]/buf_data[k] <= drv_addr[k]/drv_data[k]; pend[k] <= 1.
  - If pend[k] was already 1 at that moment, overrun[k] <= 1. New data overwrites old; the old write is never issued.
  - mem_wren <= 0 and drv_ack <= 0 in this cycle; no issue takes place on a ph2 cycle.
- ph2=0 and slot<NDR:
  - If pend[slot]=1: mem_wren <= 1; mem_addr <= buf_addr[slot]; mem_data <= buf_data[slot]; drv_select <= slot; drv_ack <= one-hot(slot); pend[slot] <= 0.
  - Else: mem_wren <= 0; drv_ack <= 0; mem_addr/mem_data hold their previous values.
  - Either way, slot <= slot+1.
- ph2=0 and slot=NDR (idle): mem_wren <= 0, drv_ack <= 0, slot holds.
- Latency: with ph2 in cycle T, drive k's write is visible on mem_* (mem_wren=1) in cycle T+2+k.
  - The slot sequence takes NDR cycles. ph2 spacing must be at least NDR+1 cycles for loss-free operation.
- Simultaneous ph2 and a pending slot: ph2 wins and the slot is not issued that cycle. The counter restarts at 0, so a still-pending write issues in the new window unless it is overwritten, in which case overrun is set.
- Skipped drives (pend=0) still consume their slot cycle, which keeps timing fixed per drive index.
- overrun clears only on reset.
- drv_select holds the last issued index when idle.
- Arithmetic: the slot counter saturates at NDR and never wraps. The index is truncated to 2 bits for drv_select.

Test Plan:
- Reset then idle, no ph2 -> all outputs 0 for 20 cycles.
- NDR=4; ph2 at T with drv_we=4'b1111, addr[k]=0x100+k, data[k]=0xA0+k:
  - mem_wren=1 at T+2..T+5 with addr 0x100..0x103 and data 0xA0..0xA3.
  - drv_select=0..3; drv_ack=0001,0010,0100,1000.
  - Idle afterwards.
- ph2 with drv_we=4'b0100, addr=0x2ABC, data=0x5A -> single write at T+4 (addr 0x2ABC, data 0x5A, drv_select=2, drv_ack=0100); mem_wren=0 at T+2, T+3, T+5.
- ph2 at T with drv_we=4'b1000, then second ph2 at T+3 with drv_we=4'b1000 and data 0x77:
  - no write at T+5.
  - write of 0x77 at T+3+5=T+8.
  - overrun=4'b1000, and it stays set.
- Reset asserted at T+3 after a 4-drive ph2 at T -> no mem_wren at T+4 or later. The next ph2 without drv_we produces no writes.
- Back-to-back ph2 spaced exactly NDR+1=5 cycles, all drives writing each window -> 4 writes per window, overrun remains 0.
